// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud arithmetic.
// The transmitter uses the same package, so both sides derive identical bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_HOLD
  } state_t;

  function automatic int baud_ratio(input int fclk, input int baudrate);
    return fclk / baudrate - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus the bit-value source for each tick.
// With UART_RX_MAJORITY_EN defined the bit value is a 2-of-3 vote over the last three rx_s samples.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic bit_s
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rx;
      sync_p1 <= sync_p0;
    end
  end

  assign rx_s = sync_p1;

`ifdef UART_RX_MAJORITY_EN
  // hist_p2 / hist_p3 hold rx_s from one and two cycles before the tick (cnt==1, cnt==2)
  logic hist_p2;
  logic hist_p3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_p2 <= 1'b1;
      hist_p3 <= 1'b1;
    end else begin
      hist_p2 <= sync_p1;
      hist_p3 <= hist_p2;
    end
  end

  assign bit_s = (sync_p1 & hist_p2) | (sync_p1 & hist_p3) | (hist_p2 & hist_p3);
`else
  assign bit_s = sync_p1;
`endif

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: rebuilds nb-bit words from the serial line and hands them over on vld/ack.
// Optional build macro UART_RX_MAJORITY_EN selects 3-sample majority voting per bit.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int fclk     = 10**9,
  parameter int baudrate = 9600,
  parameter int nb       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic          ack,
  output logic [nb-1:0] dout,
  output logic          vld,
  output logic          ovr,
  output logic          ferr,
  output logic          busy
);

  localparam int RATIO = baud_ratio(fclk, baudrate);
  localparam int HALF  = RATIO / 2;
  localparam int CNT_W = $clog2(RATIO + 1);
  localparam int IDX_W = $clog2(nb + 1);

  if (nb < 1 || nb > 16) begin : g_nb_chk
    $error("uart_rx_deframer: nb must be in 1..16");
  end

`ifdef UART_RX_MAJORITY_EN
  if (RATIO < 2) begin : g_ratio_chk
    $error("uart_rx_deframer: majority voting needs fclk/baudrate-1 >= 2");
  end
`endif

  logic rx_s;
  logic bit_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .rx_s  (rx_s),
    .bit_s (bit_s)
  );

  state_t             st, st_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [nb-1:0]      sh, sh_nxt;
  logic               tick;
  logic               load;
  logic               ferr_set;

  assign tick = (st != ST_IDLE) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    idx_nxt  = idx;
    sh_nxt   = sh;
    load     = 1'b0;
    ferr_set = 1'b0;
    if (st != ST_IDLE) begin
      cnt_nxt = (cnt == '0) ? CNT_W'(RATIO) : cnt - CNT_W'(1);
    end
    case (st)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_nxt = CNT_W'(HALF);
          st_nxt  = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!bit_s) begin
            idx_nxt = '0;
            st_nxt  = ST_DATA;
          end else begin
            st_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          // line order is LSB first, so each new bit enters at the top and walks down
          sh_nxt         = sh >> 1;
          sh_nxt[nb-1]   = bit_s;
          idx_nxt        = idx + IDX_W'(1);
          if (idx == IDX_W'(nb - 1)) st_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_s) begin
            load   = 1'b1;
            st_nxt = ST_IDLE;
          end else begin
            ferr_set = 1'b1;
            st_nxt   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (rx_s) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= '0;
      sh   <= '0;
      dout <= '0;
      vld  <= 1'b0;
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      idx  <= idx_nxt;
      sh   <= sh_nxt;
      ferr <= ferr_set;
      // a new word beats a coinciding ack; ack still consumes the old word, so no overrun
      if (load) begin
        dout <= sh;
        vld  <= 1'b1;
        if (ack)      ovr <= 1'b0;
        else if (vld) ovr <= 1'b1;
      end else if (ack && vld) begin
        vld <= 1'b0;
        ovr <= 1'b0;
      end
    end
  end

  assign busy = (st != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer at fclk=1600, baudrate=100 (16 clocks per bit, half=7).
// Stimulus pushes expected words/framing errors; a negedge monitor pops and compares.
module tb_uart_rx_deframer;

  localparam int NB = 8;
  localparam int BITC = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          ack;
  logic [NB-1:0] dout;
  logic          vld;
  logic          ovr;
  logic          ferr;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    bit         ovr;
  } exp_t;

  exp_t sb_q[$];

  uart_rx_deframer #(.fclk(1600), .baudrate(100), .nb(NB)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .ack  (ack),
    .dout (dout),
    .vld  (vld),
    .ovr  (ovr),
    .ferr (ferr),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a new word is a vld rise, a dout change while vld, or an ovr rise
  logic          vld_q  = 1'b0;
  logic          ovr_q  = 1'b0;
  logic          ferr_q = 1'b0;
  logic [NB-1:0] dout_q = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ferr) begin
        if (ferr_q) chk("ferr_single_pulse", 32'(ferr_q), 32'd0);
        else if (sb_q.size() == 0) chk("unexpected_ferr", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("ferr_expected", 32'(e.is_ferr), 32'd1);
        end
      end
      if (vld && (!vld_q || dout != dout_q || (ovr && !ovr_q))) begin
        if (sb_q.size() == 0) chk("unexpected_vld", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("word_kind", 32'(e.is_ferr), 32'd0);
          chk("word_dout", 32'(dout), 32'(e.data));
          chk("word_ovr", 32'(ovr), 32'(e.ovr));
        end
      end
    end
    vld_q  <= vld;
    ovr_q  <= ovr;
    ferr_q <= ferr;
    dout_q <= dout;
  end

  function automatic logic line_val(input logic [7:0] d, input logic stop_b, input int c);
    int j;
    j = c / BITC;
    if (j == 0) return 1'b0;
    if (j <= NB) return d[j-1];
    return stop_b;
  endfunction

  // Drives one 10-bit frame; cycle c is captured by sync flop 1 at edge E0+c
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int glitch_c,
                            input int rst_c, input bit lat_chk);
    for (int c = 0; c < 10 * BITC; c++) begin
      if (c == rst_c) begin
        rx  = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_vld", 32'(vld), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ferr_ovr", {ferr, ovr}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      rx = line_val(d, stop_b, c) ^ (c == glitch_c);
      @(posedge clk);
      #1;
      if (lat_chk && c == 153) chk("latency_vld_before", 32'(vld), 32'd0);
      if (lat_chk && c == 154) chk("latency_vld_at", 32'(vld), 32'd1);
      if (lat_chk && c == 20)  chk("busy_in_frame", 32'(busy), 32'd1);
    end
    rx = 1'b1;
  endtask

  task automatic push_word(input logic [7:0] d, input bit o);
    exp_t e;
    e.is_ferr = 1'b0;
    e.data    = d;
    e.ovr     = o;
    sb_q.push_back(e);
  endtask

  task automatic push_ferr();
    exp_t e;
    e.is_ferr = 1'b1;
    e.data    = '0;
    e.ovr     = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_vld", 32'(vld), 32'd0);
    chk("reset_ovr", 32'(ovr), 32'd0);
    chk("reset_ferr", 32'(ferr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // '$' with exact latency, then ack
    push_word(8'h24, 1'b0);
    send_frame(8'h24, 1'b1, -1, -1, 1'b1);
    chk("t1_dout", 32'(dout), 32'h24);
    do_ack();
    chk("t1_ack_vld", 32'(vld), 32'd0);

    // 4-cycle low glitch is rejected at start sample
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
    chk("glitch_busy_start", 32'(busy), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("glitch_busy_idle", 32'(busy), 32'd0);
    chk("glitch_no_vld", 32'(vld), 32'd0);

    // framing error, stuck-low line, then recovery
    push_ferr();
    send_frame(8'h47, 1'b0, -1, -1, 1'b0);
    rx = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_no_vld", 32'(vld), 32'd0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_exit", 32'(busy), 32'd0);
    push_word(8'h50, 1'b0);
    send_frame(8'h50, 1'b1, -1, -1, 1'b0);
    chk("t3_dout", 32'(dout), 32'h50);
    do_ack();

    // back-to-back without ack -> overrun
    push_word(8'h47, 1'b0);
    push_word(8'h50, 1'b1);
    send_frame(8'h47, 1'b1, -1, -1, 1'b0);
    send_frame(8'h50, 1'b1, -1, -1, 1'b0);
    chk("ovr_dout", 32'(dout), 32'h50);
    chk("ovr_vld", 32'(vld), 32'd1);
    chk("ovr_flag", 32'(ovr), 32'd1);
    do_ack();
    chk("ovr_ack_vld", 32'(vld), 32'd0);
    chk("ovr_ack_ovr", 32'(ovr), 32'd0);

    // reset in the middle of data bit 3, then a clean frame
    send_frame(8'h2C, 1'b1, -1, 4 * BITC + 6, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    push_word(8'h2C, 1'b0);
    send_frame(8'h2C, 1'b1, -1, -1, 1'b0);
    chk("t5_dout", 32'(dout), 32'h2C);
    do_ack();

    // one-cycle glitch at data bit 0 mid-sample
`ifdef UART_RX_MAJORITY_EN
    push_word(8'h55, 1'b0);
`else
    push_word(8'h54, 1'b0);
`endif
    send_frame(8'h55, 1'b1, 2 * BITC - 8, -1, 1'b0);
    do_ack();

    repeat (20) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Serial UART receiver; the stage directly downstream of the UART transmitter.
- Consumes the 8N1 serial line (idle high, start bit 0, nb data bits LSB first, one stop bit 1) and rebuilds parallel bytes.
- Presents each byte on a valid/ack interface to the NMEA/GPS parsing logic.
- Uses the same baud arithmetic as the transmitter (fclk, baudrate, nb), so the two pair directly in simulation.

Parameters:
- fclk, 10**9, clock frequency in Hz
- baudrate, 9600, line bit rate in baud
- nb, 8, data bits per frame (1..16)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rx  in  1  serial line, asynchronous to clk, idle high
- ack  in  1  consumer acknowledges dout; clears vld
- dout  out  nb  last received data byte
- vld  out  1  dout holds an unacknowledged byte
- ovr  out  1  sticky overrun flag
- ferr  out  1  one-cycle framing-error pulse
- busy  out  1  frame reception in progress

Behaviour:
- Constants: ratio = fclk/baudrate - 1; half = ratio/2 (integer division).
- Bit counter: cnt is $clog2(ratio+1) bits; bit index is $clog2(nb+1) bits.
- Synchroniser: rx passes through a 2-flop synchroniser (reset to 1), giving rx_s. All decisions use rx_s only.
- Reset values: dout=0, vld=0, ovr=0, ferr=0, busy=0, st=idle, cnt=0, bit index=0, shift register=0.
- Baud counter, used in every non-idle state:
  - If cnt!=0: decrement.
  - If cnt==0: sample rx_s ("tick") and reload cnt=ratio.
- State machine {idle, start, data, stop, hold}:
  - idle: rx_s==0 -> cnt=half, go to start.
  - start, on tick: rx_s==0 -> bit index=0, go to data. rx_s==1 -> glitch rejected, go to idle, no outputs change.
  - data, on tick: shift rx_s in at the MSB (LSB-first line order) and increment the bit index. After the nb-th sample -> go to stop.
  - stop, on tick with rx_s==1: dout<=shift register and vld<=1, in the same edge. If vld was already 1 and ack is not high that cycle, set ovr<=1 (new byte overwrites). Go to idle.
  - stop, on tick with rx_s==0: ferr=1 for one cycle; dout, vld and ovr are unchanged. Go to hold.
  - hold: stay until rx_s==1 (break/stuck-low line), then go to idle. No re-arming while the line is low.
- busy = (st != idle). busy is registered through the state register.
- Latency: let E0 be the first clk edge at which rx is captured low by sync flop 1.
  - Start-bit sample at E0+3+half.
  - Data bit k (0-based) sampled at E0+3+half+(k+1)(ratio+1).
  - Stop bit sampled at E0+3+half+(nb+1)(ratio+1); vld is visible after that edge.
- ack: clears vld on the edge where ack=1 and also clears ovr. If ack and a new stop-tick load coincide, the load wins: vld stays 1 and ovr is not set. ack while vld=0 is ignored.
- Back-to-back frames: the next start bit is accepted in idle on the cycle after the stop tick. No inter-frame gap is needed.
- Reset mid-frame: all state is cleared immediately. Any partial byte is discarded and no vld or ferr is generated.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- When defined: each tick samples rx_s at cnt==1, cnt==0, and the previous cycle (cnt==2), and uses the 2-of-3 majority vote as the bit value. This applies to start, data and stop decisions.
- When not defined: a single sample of rx_s at cnt==0.
- Latency is identical either way. Requires ratio>=2 (enforced by an elaboration-time assertion).

Decomposition:
- Shared package uart_pkg:
  - states enum {idle, start, data, stop, hold}
  - function baud_ratio(fclk, baudrate) returning fclk/baudrate-1
  - shared with the transmitter so both sides derive identical timing.
- One natural sub-module: uart_rx_sync. It holds the 2-flop synchroniser plus the optional majority voter and outputs the sampled bit on tick.

Test Plan (fclk=1600, baudrate=100 → ratio=15, half=7, nb=8):
- Send 0x24 ('$') 8N1 → vld rises after edge E0+154 with dout=0x24, ferr=0, ovr=0; ack → vld=0 next edge.
- rx low pulse of 4 cycles, then high → start rejected, busy returns to 0, no vld or ferr.
- Frame 0x47 with stop bit forced 0, then line held low 100 cycles, then high → ferr pulses once; state is hold until rx high; no vld; next valid frame 0x50 received correctly.
- Two frames 0x47, 0x50 back-to-back with no ack → dout=0x50, vld=1, ovr=1; ack clears both.
- Assert rst in the middle of data bit 3 → all outputs 0 immediately; the following clean frame 0x2C is received correctly.
- With UART_RX_MAJORITY_EN: a 1-cycle inverted glitch at the data-bit mid-sample of frame 0x55 → dout=0x55. Without the macro the glitch is captured (dout≠0x55).
